// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic test path: FSM state encoding
// and the bit-counter width helper.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must be able to hold bit indices 0..w inclusive.
   function automatic int cnt_width(input int w);
      return (w < 1) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: d = y - b - br_in, with borrow-out.
module serial_sub_cell (
   input  logic y_i,
   input  logic b_i,
   input  logic br_in,
   output logic d_i,
   output logic br_out
);

   assign d_i    = y_i ^ b_i ^ br_in;
   assign br_out = (~y_i & b_i) | (~(y_i ^ b_i) & br_in);

endmodule

// File: rtl/serial_sub_recover.sv
// Bit-serial recovery of addend a = y - b, LSB first over W+1 cycles.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid/ready never depend combinationally on the other side.
module serial_sub_recover
   import arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W:0]   y,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] a,
   output logic         err
);

   localparam int CW = cnt_width(W);

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [W:0]    y_sr;
   logic [W:0]    b_sr;
   logic [W:0]    d_sr;
   logic [W:0]    d_nx;
   logic          br;
   logic          d_i;
   logic          br_out;
   logic          last_bit;

   serial_sub_cell u_cell (
      .y_i    (y_sr[0]),
      .b_i    (b_sr[0]),
      .br_in  (br),
      .d_i    (d_i),
      .br_out (br_out)
   );

   assign d_nx      = {d_i, d_sr[W:1]};
   assign last_bit  = (cnt == CW'(W));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = SHIFT;
         SHIFT:   if (last_bit)  state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // b is zero-extended so bit W subtracts only the pending borrow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_sr <= '0;
         b_sr <= '0;
         d_sr <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         a    <= '0;
         err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  y_sr <= y;
                  b_sr <= {1'b0, b};
                  d_sr <= '0;
                  br   <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               y_sr <= y_sr >> 1;
               b_sr <= b_sr >> 1;
               d_sr <= d_nx;
               br   <= br_out;
               cnt  <= cnt + 1'b1;
               if (last_bit) begin
                  a   <= d_nx[W-1:0];
                  err <= br_out | d_i;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_recover.sv
// Directed bench for serial_sub_recover (W=4) with hand-computed results.
module tb_serial_sub_recover;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   y;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic         err;

  int err_cnt;
  int chk_cnt;
  logic [W:0] exp_q[$];

  serial_sub_recover #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one operation; expects the result W+1 cycles after acceptance and
  // holds out_ready low for bp cycles before taking it.
  task automatic run_op(input logic [W:0] yv, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_a, input logic exp_err,
                        input int bp, input bit toggle);
    logic [W:0] got;
    logic [W:0] exp;
    y        = yv;
    b        = bv;
    in_valid = 1'b1;
    check("accept_in_ready", in_ready, 1);
    check("accept_out_valid", out_valid, 0);
    exp_q.push_back({exp_err, exp_a});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("shift_in_ready", in_ready, 0);
    for (int k = 1; k <= W + 1; k++) begin
      if (toggle) begin
        y        = W'($urandom_range(0, 31));
        b        = (W)'($urandom_range(0, 15));
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (k < W + 1) check("latency_no_valid", out_valid, 0);
      else           check("latency_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < bp; c++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_a", a, exp_a);
      check("bp_err", err, exp_err);
    end
    got       = {err, a};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check("result_a", got[W-1:0], exp[W-1:0]);
      check("result_err", got[W], exp[W]);
    end
    check("done_out_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_a", a, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(5'd30, 4'd15, 4'hF, 1'b0, 0, 1'b0);  // max legal sum
    run_op(5'd7,  4'd9,  4'hE, 1'b1, 0, 1'b0);  // underflow
    run_op(5'd20, 4'd2,  4'h2, 1'b1, 0, 1'b0);  // overflow, d_W set
    run_op(5'd0,  4'd0,  4'h0, 1'b0, 0, 1'b1);  // zero, inputs toggling
    run_op(5'd12, 4'd5,  4'h7, 1'b0, 3, 1'b0);  // backpressure
    run_op(5'd31, 4'd0,  4'hF, 1'b1, 1, 1'b1);  // 31 - 0 exceeds W bits

    // Abort an operation mid-SHIFT; a holds 4'hF from the previous result.
    y        = 5'd30;
    b        = 4'd15;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_a", a, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk); #1;
      check("postrst_no_valid", out_valid, 0);
      check("postrst_in_ready", in_ready, 1);
    end
    run_op(5'd3, 4'd1, 4'h2, 1'b0, 0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_sub_recover.md
# serial_sub_recover

Bit-serial subtractor that inverts the 4-bit adder datapath. Given a sum `y` (W+1 bits) and one addend `b` (W bits), it recovers the other addend `a = y - b`. The operands are processed LSB-first over W+1 cycles, with valid/ready handshakes on both sides. It sits downstream of the adder in the arithmetic test path and serves as its checker/decoder. It flags any result that cannot have come from a W-bit addend.

## Interface
- `W`, default 4: addend width; sum width is W+1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `y`  in  W+1  sum operand, unsigned.
- `b`  in  W  known addend, unsigned.
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  consumer takes result.
- `a`  out  W  recovered addend: low W bits of (y - b) mod 2^(W+1).
- `err`  out  1  set if y < b (final borrow) or y - b > 2^W - 1 (bit W of difference set).

## Operation
- FSM states are IDLE, SHIFT, DONE.
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `a`=0, `err`=0, bit counter 0, borrow 0.
- **IDLE:**
  - `in_valid & in_ready` at an edge latches `y` and `b` into shift registers, clears borrow and counter, and moves to SHIFT.
  - `in_valid` without a handshake has no effect.
- **SHIFT:** each edge processes one bit i (i = 0..W):
  - d_i = y_i ^ b_i ^ br
  - br' = (~y_i & b_i) | (~(y_i ^ b_i) & br)
  - b_W is taken as 0.
  - d_i shifts into the result register, and the counter increments.
  - After bit W is processed, the block enters DONE.
- **On entering DONE:**
  - `a` = d[W-1:0].
  - `err` = br_final | d_W.
  - `a` and `err` are registered and held stable for the whole of DONE.
- **DONE:** `out_valid`=1. When `out_valid & out_ready` occurs at an edge, the block returns to IDLE. `a` and `err` keep their last values until the next DONE; consumers must qualify them with `out_valid`.
- **Input isolation:** `y`, `b` and `in_valid` are ignored outside the IDLE handshake, so input changes during SHIFT or DONE do not affect the result.
- **Arithmetic:** all values are unsigned, and the difference is computed modulo 2^(W+1). No saturation is applied; `err` is the only overflow/underflow indication.
- **Reset mid-operation:** an asynchronous reset in SHIFT or DONE aborts the operation. The result is discarded, no `out_valid` pulse is produced, and the block returns to the reset values.

## Timing
- Accept handshake occurs at edge E0.
- Bits 0..W are processed on edges E1..E(W+1).
- `out_valid` is high after edge E(W+1), i.e. W+1 cycles after acceptance (5 cycles for W=4).
- `in_ready` is low from after E0 until the edge that completes the output handshake; it is high in the following cycle.
- There is no overlap of operations. Minimum period is W+3 cycles per result when `out_ready` is held high.
- `in_ready` and `out_valid` are decoded directly from registered state, so there are no combinational paths from inputs to outputs.
- Backpressure is unlimited: DONE holds indefinitely while `out_ready` is 0.

## Structure
- **Shared package `arith_pkg`:**
  - state enum typedef {IDLE, SHIFT, DONE}.
  - function/constant for counter width `$clog2(W+1)`.
- **Sub-module `serial_sub_cell`:** a combinational one-bit full subtractor with inputs (y_i, b_i, br_in) and outputs (d_i, br_out), instantiated once.
- **Top level contains:** the FSM, counter, operand shift registers, result shift register, and borrow flop.

## Test plan
All scenarios use W=4.
- **Max legal sum:** y=30, b=15 accepted at E0 -> `out_valid` after E5, `a`=4'hF, `err`=0. `in_ready` returns 1 the cycle after the output handshake.
- **Underflow:** y=7, b=9 -> `a`=4'hE, `err`=1.
- **Overflow:** y=20, b=2 (difference 18) -> `a`=4'h2, `err`=1.
- **Zero operands:** y=0, b=0 -> `a`=0, `err`=0. Also apply `y` and `b` toggling during SHIFT -> result unchanged.
- **Backpressure:** y=12, b=5 with `out_ready` low for 3 cycles -> `out_valid`=1, `a`=7 and `err`=0 held stable, `in_ready`=0 throughout. Output handshake completes when `out_ready` rises.
- **Reset mid-SHIFT:** assert `rst_n`=0 after E2 -> outputs go immediately to reset values. After release: `in_ready`=1, no `out_valid` pulse, and the next operation (y=3, b=1 -> `a`=2) completes normally.
